// File: rtl/reg_file_pkg.sv
// Shared types and constants for the parametrised register file.
// Optional same-cycle read bypass is enabled with RF_BYPASS_EN.
package reg_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  localparam int ZERO_REG = 0;
  localparam int FLAG_REG = 1;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks every entry to zero after reset,
// then holds READY until reset is sampled again.
module reg_file_clr_seq
  import reg_file_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  rf_state_t     state;
  logic [AW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= READY;
          end
        end
        READY: begin
          ptr <= ptr;
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy && !reset;
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_param.sv
// Register file: two combinational reads, one write port, a flag
// write path into entry 1; RF_BYPASS_EN adds same-cycle read bypass.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int FW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic          flag_en,
  input  logic [FW-1:0] flag,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busy,
  output logic          wr_err
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] ZADDR = AW'(ZERO_REG);
  localparam logic [AW-1:0] FADDR = AW'(FLAG_REG);

  logic [DW-1:0] core [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          live;
  logic          flag_we;
  logic          gen_we;
  logic [DW-1:0] flag_ext;

  reg_file_clr_seq #(
    .AW(AW)
  ) u_clr (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign live     = !busy && !reset;
  assign flag_ext = DW'(flag);
  assign flag_we  = live && flag_en;
  assign gen_we   = live && wr_en && !flag_en
                 && (wr_addr != ZADDR)
                 && (wr_addr != FADDR);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      core[clr_addr] <= '0;
    end else if (flag_we) begin
      core[FLAG_REG] <= flag_ext;
    end else if (gen_we) begin
      core[wr_addr] <= dat_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !gen_we;
    end
  end

  function automatic logic [DW-1:0] rd_port(
    input logic [AW-1:0] a
  );
    logic [DW-1:0] v;
    v = core[a];
`ifdef RF_BYPASS_EN
    if (flag_we && a == FADDR) begin
      v = flag_ext;
    end else if (gen_we && a == wr_addr) begin
      v = dat_in;
    end
`endif
    if (busy || a == ZADDR) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    datA_out = rd_port(rd_addrA);
    datB_out = rd_port(rd_addrB);
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench: stimulus queues expected outputs, a monitor
// pops and compares them on each falling edge.
module tb_reg_file_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] dat_in;
  logic       flag_en;
  logic [0:0] flag;
  logic [2:0] rd_addrA;
  logic [2:0] rd_addrB;
  logic [7:0] datA_out;
  logic [7:0] datB_out;
  logic       busy;
  logic       wr_err;

  int n_chk  = 0;
  int n_pass = 0;

  int         q_sig [$];
  logic [7:0] q_exp [$];
  string      q_nm  [$];

  always #5 clk = ~clk;

  reg_file_param #(
    .DW(8),
    .AW(3),
    .FW(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .dat_in  (dat_in),
    .flag_en (flag_en),
    .flag    (flag),
    .rd_addrA(rd_addrA),
    .rd_addrB(rd_addrB),
    .datA_out(datA_out),
    .datB_out(datB_out),
    .busy    (busy),
    .wr_err  (wr_err)
  );

  // sig: 0=datA 1=datB 2=busy 3=wr_err
  task automatic expect_v(
    input int s, input logic [7:0] e, input string n
  );
    q_sig.push_back(s);
    q_exp.push_back(e);
    q_nm.push_back(n);
  endtask

  task automatic chk1(
    input logic a, input logic e, input string n
  );
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t",
                  n, a, e, $time);
  endtask

  always @(negedge clk) begin
    while (q_sig.size() > 0) begin
      int         s;
      logic [7:0] e;
      logic [7:0] act;
      string      n;
      s = q_sig.pop_front();
      e = q_exp.pop_front();
      n = q_nm.pop_front();
      case (s)
        0:       act = datA_out;
        1:       act = datB_out;
        2:       act = {7'b0, busy};
        default: act = {7'b0, wr_err};
      endcase
      n_chk++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t",
                    n, act, e, $time);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    int w;
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    dat_in   = '0;
    flag_en  = 1'b0;
    flag     = '0;
    rd_addrA = 3'd4;
    rd_addrB = 3'd0;
    cyc();
    cyc();
    chk1(busy, 1'b1, "rst_busy_now");
    chk1(wr_err, 1'b0, "rst_err_now");
    expect_v(2, 8'h01, "rst_busy");
    expect_v(3, 8'h00, "rst_err");
    expect_v(0, 8'h00, "rst_datA");
    cyc();
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      expect_v(2, 8'h01, "clr_busy");
      expect_v(0, 8'h00, "clr_datA");
      if (i == 2) begin
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        dat_in  = 8'h77;
      end else begin
        wr_en = 1'b0;
      end
      if (i == 3) expect_v(3, 8'h01, "clr_err");
      if (i == 4) expect_v(3, 8'h00, "clr_err_low");
      cyc();
    end
    wr_en = 1'b0;
    expect_v(2, 8'h00, "busy_done");
    w = 0;
    while (busy && w < 20) begin
      cyc();
      w++;
    end
    chk1(busy, 1'b0, "busy_wait_expired");

    for (int a = 0; a < 8; a++) begin
      rd_addrA = 3'(a);
      rd_addrB = 3'(7 - a);
      expect_v(0, 8'h00, "cleared_A");
      expect_v(1, 8'h00, "cleared_B");
      cyc();
    end

    wr_en   = 1'b1;
    wr_addr = 3'd3;
    dat_in  = 8'hA5;
    cyc();
    wr_en    = 1'b0;
    rd_addrA = 3'd3;
    rd_addrB = 3'd3;
    expect_v(0, 8'hA5, "r3_A");
    expect_v(1, 8'hA5, "r3_B");
    expect_v(3, 8'h00, "r3_err");
    cyc();

    wr_en   = 1'b1;
    wr_addr = 3'd0;
    dat_in  = 8'hFF;
    cyc();
    expect_v(3, 8'h01, "r0_err");
    wr_addr = 3'd1;
    dat_in  = 8'h7E;
    cyc();
    expect_v(3, 8'h01, "r1_err");
    wr_en    = 1'b0;
    rd_addrA = 3'd0;
    rd_addrB = 3'd1;
    expect_v(0, 8'h00, "r0_zero");
    expect_v(1, 8'h00, "r1_kept");
    cyc();
    expect_v(3, 8'h00, "err_clear");

    flag_en = 1'b1;
    flag    = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd5;
    dat_in  = 8'h33;
    cyc();
    flag_en  = 1'b0;
    wr_en    = 1'b0;
    rd_addrA = 3'd1;
    rd_addrB = 3'd5;
    expect_v(3, 8'h01, "flag_conf_err");
    expect_v(0, 8'h01, "flag_r1");
    expect_v(1, 8'h00, "flag_r5_kept");
    cyc();

    wr_en    = 1'b1;
    wr_addr  = 3'd2;
    dat_in   = 8'h5C;
    rd_addrA = 3'd2;
`ifdef RF_BYPASS_EN
    expect_v(0, 8'h5C, "byp_r2");
`else
    expect_v(0, 8'h00, "nobyp_r2");
`endif
    cyc();
    wr_en = 1'b0;
    expect_v(0, 8'h5C, "r2_after");
    expect_v(3, 8'h00, "r2_err");

    flag_en  = 1'b1;
    flag     = 1'b0;
    rd_addrB = 3'd1;
`ifdef RF_BYPASS_EN
    expect_v(1, 8'h00, "byp_flag");
`else
    expect_v(1, 8'h01, "nobyp_flag");
`endif
    cyc();
    flag_en = 1'b0;
    expect_v(1, 8'h00, "flag_after");

    wr_en    = 1'b1;
    wr_addr  = 3'd1;
    dat_in   = 8'hEE;
    rd_addrA = 3'd1;
    expect_v(0, 8'h00, "drop_nobyp");
    cyc();
    wr_en = 1'b0;
    expect_v(0, 8'h00, "drop_after");

    wr_en   = 1'b1;
    wr_addr = 3'd6;
    dat_in  = 8'h11;
    cyc();
    wr_en    = 1'b0;
    rd_addrA = 3'd6;
    expect_v(0, 8'h11, "r6_set");
    cyc();

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_v(2, 8'h01, "re_busy");
      expect_v(0, 8'h00, "re_datA");
      cyc();
    end
    rd_addrB = 3'd3;
    expect_v(2, 8'h00, "re_done");
    expect_v(0, 8'h00, "r6_cleared");
    expect_v(1, 8'h00, "r3_cleared");
    cyc();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised general-purpose register file for the core datapath: two combinational read ports, one clocked write port and a dedicated flag-write path into the flag register. It generalises width, depth and flag width. It adds a synchronous-reset clear sequencer, a busy indication and a dropped-write error pulse. It sits between decode (addresses), the ALU/load path (write data) and the compare unit (flag).

## Interface
- DW, 8, data width in bits
- AW, 3, address width; DEPTH = 2**AW entries
- FW, 1, flag width; FW <= DW
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- wr_en  input  1  general write request
- wr_addr  input  AW  write address
- dat_in  input  DW  write data
- flag_en  input  1  flag write request
- flag  input  FW  flag value
- rd_addrA  input  AW  read address A
- rd_addrB  input  AW  read address B
- datA_out  output  DW  read data A, combinational
- datB_out  output  DW  read data B, combinational
- busy  output  1  clear sequence in progress
- wr_err  output  1  registered one-cycle pulse: a general write was dropped

## Operation
- Entry 0 (ZERO_REG) reads as 0 always; it is never written.
- Entry 1 (FLAG_REG) is written only by the flag path, as {(DW-FW) zeros, flag}.
- FSM states:
  - CLEAR: a pointer ptr walks the array.
  - READY: normal operation.
- Reset sampled high: state <= CLEAR, ptr <= 0, wr_err <= 0.
- CLEAR, each cycle with reset low:
  - core[ptr] <= 0 and ptr <= ptr+1.
  - At ptr == DEPTH-1, state <= READY.
- Reset reasserted mid-CLEAR: ptr restarts at 0.
- busy = (state == CLEAR), so busy is 1 out of reset.
- During CLEAR:
  - datA_out and datB_out read 0.
  - All writes and flag writes are ignored.
  - wr_err pulses for each wr_en.
- READY, priority order:
  - flag_en: core[1] <= zero-extended flag. A simultaneous general write to any address is dropped.
  - Otherwise wr_en with wr_addr not 0 and not 1: core[wr_addr] <= dat_in.
  - Otherwise wr_en with wr_addr 0 or 1: no write.
- wr_err <= 1 on the next edge whenever wr_en=1 and no general write occurred (busy, protected address, or flag_en conflict). Otherwise wr_err <= 0.
- Reads: index core[rd_addr] with rd_addr 0 mapped to 0. Ports A and B are independent; both may address the same entry.

## Timing
- A write is visible on the read ports in the cycle after the clock edge. Same-cycle visibility applies only with bypass (see Configuration).
- Clear latency: busy is high for exactly DEPTH cycles after reset falls. The first accepted write is in cycle DEPTH+1 after release.
- wr_err lags the offending request by one cycle.
- Reset values:
  - busy = 1
  - wr_err = 0
  - read outputs = 0 (because of busy)
  - entry contents = 0 after CLEAR completes

## Configuration
- RF_BYPASS_EN defined: in READY, a read address that matches an accepted same-cycle write returns that write's data combinationally.
  - Flag path: read address 1 with flag_en=1 returns the zero-extended flag.
  - General path: a read address matching an accepted general write returns dat_in.
  - Dropped writes are never bypassed.
- Undefined: reads always return stored contents, i.e. pre-edge data on a same-cycle match.

## Structure
- Package reg_file_pkg holds:
  - state enum rf_state_t {CLEAR, READY}
  - localparams ZERO_REG = 0 and FLAG_REG = 1
- Sub-module reg_file_clr_seq (parameter AW) holds the FSM and ptr.
  - Outputs: busy, clr_we, clr_addr.
  - The array and port logic stay in reg_file_param.

## Test plan
- Reset for 2 cycles, then release with DW=8, AW=3 -> busy high exactly 8 cycles; datA_out=0 throughout; then every entry reads 0.
- Write 0xA5 to r3, read r3 on A and B the next cycle -> 0xA5 on both; wr_err=0.
- wr_en to r0 with 0xFF, then to r1 with 0x7E -> r0 reads 0, r1 unchanged; wr_err pulses 1 the cycle after each.
- flag_en=1 with flag=1 and wr_en to r5 with 0x33 in the same cycle -> r1 reads 0x01; r5 unchanged; wr_err=1 next cycle.
- Write 0x5C to r2 while reading r2 in the same cycle -> 0x5C combinationally with RF_BYPASS_EN, old value without it.
- Reassert reset at CLEAR cycle 4 after r6=0x11 was written -> busy stays high a full 8 cycles after release; r6 reads 0.
